// File: rtl/character_motion_fsm.sv
// character_motion_fsm
// Movement state machine and integer physics integrator for the player sprite.
// Advances once per character_clk strobe: walking, jump charging, launch,
// airborne gravity with wall/ceiling response, landing and jump-release hold.
// Every output comes straight from a register so the display controller and
// the position integrator see a stable value for a whole tick.

module character_motion_fsm #(
    parameter int SIGNED_PHY_WIDTH = 17,
    parameter int MAX_VEL_Y        = 10,
    parameter int MAX_VEL_X        = 4,
    parameter int WALK_VEL         = 2,
    parameter int GRAVITY          = 1,
    parameter int CHARGE_SHIFT     = 5
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               character_clk,
    input  logic                               btn_left,
    input  logic                               btn_right,
    input  logic                               btn_jump,
    input  logic                               on_ground,
    input  logic                               hit_wall_x,
    input  logic                               hit_ceiling,
    output logic [2:0]                         char_state,
    output logic signed [SIGNED_PHY_WIDTH-1:0] vel_x,
    output logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
    output logic                               face_dir,
    output logic                               airborne,
    output logic [CHARGE_SHIFT:0]              charge_level
);

    localparam int W      = SIGNED_PHY_WIDTH;
    localparam int CW     = CHARGE_SHIFT + 1;
    // Launch product is formed wide enough that MAX_VEL_Y * MAX_CHARGE never wraps.
    localparam int PROD_W = W + CHARGE_SHIFT + 1;

    localparam logic [CW-1:0]       MAX_CHARGE   = CW'(1 << CHARGE_SHIFT);
    localparam logic signed [W-1:0] VEL_ZERO     = '0;
    localparam logic signed [W-1:0] VEL_ONE      = W'(1);
    localparam logic signed [W-1:0] WALK_POS     = W'(WALK_VEL);
    localparam logic signed [W-1:0] WALK_NEG     = -WALK_POS;
    localparam logic signed [W-1:0] LAUNCH_X_POS = W'(MAX_VEL_X);
    localparam logic signed [W-1:0] LAUNCH_X_NEG = -LAUNCH_X_POS;
    // Gravity and the terminal-velocity clamp are evaluated one bit wider so
    // the subtraction cannot overflow before the clamp catches it.
    localparam logic signed [W:0]   GRAV_EXT     = (W + 1)'(GRAVITY);
    localparam logic signed [W:0]   FALL_LIMIT   = -((W + 1)'(MAX_VEL_Y));
    localparam logic signed [W-1:0] FALL_LIMIT_W = FALL_LIMIT[W-1:0];

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEFT      = 3'd1,
        ST_RIGHT     = 3'd2,
        ST_CHARGE    = 3'd3,
        ST_JUMP      = 3'd4,
        ST_COLLISION = 3'd5,
        ST_FALL      = 3'd6,
        ST_HOLD      = 3'd7
    } state_t;

    state_t           state;
    logic signed [1:0] jump_dir;

    // Direction decode: exactly one horizontal button counts as a direction.
    logic              only_left;
    logic              only_right;
    logic signed [1:0] dir_now;
    logic              face_after_dir;

    assign only_left      = btn_left & ~btn_right;
    assign only_right     = btn_right & ~btn_left;
    assign dir_now        = only_left ? -2'sd1 : (only_right ? 2'sd1 : 2'sd0);
    assign face_after_dir = only_left ? 1'b0 : (only_right ? 1'b1 : face_dir);

    // Charge counter advance, saturating at full charge.
    logic [CW-1:0] charge_inc;
    logic          charge_full;

    assign charge_full = (charge_level == MAX_CHARGE);
    assign charge_inc  = charge_full ? MAX_CHARGE : charge_level + CW'(1);

    // Launch speed scales with charge; a tap still produces a minimal hop.
    logic [PROD_W-1:0]  launch_prod;
    logic [PROD_W-1:0]  launch_shifted;
    logic signed [W-1:0] launch_vel_y;
    logic signed [W-1:0] launch_vel_x;
    logic signed [W-1:0] latched_vel_x;

    assign launch_prod    = PROD_W'(MAX_VEL_Y) * PROD_W'(charge_level);
    assign launch_shifted = launch_prod >> CHARGE_SHIFT;
    assign launch_vel_y   = (launch_shifted == '0) ? VEL_ONE : launch_shifted[W-1:0];
    assign launch_vel_x   = only_left ? LAUNCH_X_NEG : (only_right ? LAUNCH_X_POS : VEL_ZERO);
    assign latched_vel_x  = (jump_dir == -2'sd1) ? LAUNCH_X_NEG :
                            ((jump_dir == 2'sd1) ? LAUNCH_X_POS : VEL_ZERO);

    // Airborne vertical update: gravity with terminal clamp, ceiling kills upward speed.
    logic signed [W:0]   vy_ext;
    logic signed [W:0]   vy_dec;
    logic signed [W-1:0] vy_gravity;
    logic signed [W-1:0] vy_air;
    logic signed [W-1:0] vx_negated;
    logic                landing;

    assign vy_ext     = {vel_y[W-1], vel_y};
    assign vy_dec     = vy_ext - GRAV_EXT;
    assign vy_gravity = (vy_dec < FALL_LIMIT) ? FALL_LIMIT_W : vy_dec[W-1:0];
    assign vy_air     = (hit_ceiling && (vel_y > VEL_ZERO)) ? VEL_ZERO : vy_gravity;
    assign vx_negated = VEL_ZERO - vel_x;
    // Only a non-rising character can land; a rising one passes through floor contact.
    assign landing    = on_ground && (vel_y <= VEL_ZERO);

    assign char_state = state;

    // Movement FSM and physics registers, advanced once per character tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            vel_x        <= '0;
            vel_y        <= '0;
            face_dir     <= 1'b1;
            airborne     <= 1'b0;
            charge_level <= '0;
            jump_dir     <= 2'sd0;
        end else if (character_clk) begin
            case (state)
                ST_IDLE, ST_COLLISION: begin
                    if (airborne) begin
                        if (landing) begin
                            // vel_y is deliberately left untouched so the
                            // display sees the impact speed on this tick.
                            state <= ST_FALL;
                            vel_x <= '0;
                        end else begin
                            vel_y <= vy_air;
                            if (hit_wall_x) begin
                                state    <= ST_COLLISION;
                                vel_x    <= vx_negated;
                                face_dir <= ~face_dir;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end else begin
                        vel_x <= '0;
                        vel_y <= '0;
                        if (btn_jump) begin
                            state        <= ST_CHARGE;
                            charge_level <= charge_inc;
                            jump_dir     <= dir_now;
                            face_dir     <= face_after_dir;
                        end else if (only_left) begin
                            state    <= ST_LEFT;
                            vel_x    <= WALK_NEG;
                            face_dir <= 1'b0;
                        end else if (only_right) begin
                            state    <= ST_RIGHT;
                            vel_x    <= WALK_POS;
                            face_dir <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_LEFT, ST_RIGHT: begin
                    if (!on_ground) begin
                        // Walked off a ledge: keep horizontal speed and start falling.
                        state    <= ST_IDLE;
                        airborne <= 1'b1;
                    end else if (btn_jump) begin
                        state        <= ST_CHARGE;
                        vel_x        <= '0;
                        charge_level <= charge_inc;
                        jump_dir     <= dir_now;
                        face_dir     <= face_after_dir;
                    end else if ((state == ST_LEFT) && only_left) begin
                        vel_x    <= WALK_NEG;
                        face_dir <= 1'b0;
                    end else if ((state == ST_RIGHT) && only_right) begin
                        vel_x    <= WALK_POS;
                        face_dir <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        vel_x <= '0;
                    end
                end

                ST_CHARGE: begin
                    jump_dir <= dir_now;
                    face_dir <= face_after_dir;
                    if (!btn_jump || charge_full) begin
                        state        <= ST_JUMP;
                        vel_y        <= launch_vel_y;
                        vel_x        <= launch_vel_x;
                        airborne     <= 1'b1;
                        charge_level <= '0;
                    end else begin
                        vel_x        <= '0;
                        charge_level <= charge_inc;
                    end
                end

                ST_JUMP: begin
                    // Launch tick: velocities were loaded on entry; begin falling now.
                    state <= ST_IDLE;
                    vel_x <= latched_vel_x;
                    vel_y <= vy_gravity;
                end

                ST_FALL: begin
                    airborne <= 1'b0;
                    vel_x    <= '0;
                    vel_y    <= '0;
                    state    <= btn_jump ? ST_HOLD : ST_IDLE;
                end

                ST_HOLD: begin
                    // Jump still held from the previous flight: wait for release.
                    vel_x <= '0;
                    vel_y <= '0;
                    state <= btn_jump ? ST_HOLD : ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
